// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared RV32 fetch-stage definitions.
//   XLEN           datapath width
//   RESET_PC       PC value after reset
//   NOP_INSTR      canonical NOP (addi x0,x0,0), used as payload of fault entries
//   fetch_state_t  fetch sequencer states
//   is_misaligned  true when an address is not 32-bit aligned
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC  = '0;
   localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_FAULT = 2'd3
   } fetch_state_t;

   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf -- one-entry valid/ready buffer at the IF/ID boundary.
//   clk, reset         clock, synchronous active-high reset
//   load               capture {ld_pc, ld_instr, ld_fault}; wins over flush/drain
//   flush              drop the held entry
//   ready              consumer accepts the held entry this cycle
//   ld_pc/ld_instr/ld_fault  entry to capture
//   valid/pc/instr/fault     held entry (registered)
module fetch_buf
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            flush,
   input  logic            ready,
   input  logic [XLEN-1:0] ld_pc,
   input  logic [31:0]     ld_instr,
   input  logic            ld_fault,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instr,
   output logic            fault
);

   // Entry payload only changes on load, so it is stable while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= '0;
         fault <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= ld_pc;
         instr <= ld_instr;
         fault <= ld_fault;
      end else if (flush || ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- RV32 instruction-fetch sequencer.
//   clk, reset                      clock, synchronous active-high reset
//   pc                              current PC from the external pc register
//   pc_en, pc_next                  PC write enable / value (combinational)
//   imem_req, imem_addr, imem_gnt   fetch request handshake (addr == pc)
//   imem_rvalid, imem_rdata         fetch response
//   redirect_valid/_target          taken branch/jump from EX
//   trap_valid/trap_vector          trap redirect, higher priority than branch
//   if_valid/if_ready/if_pc/if_instr/if_fault  one-entry output buffer to decode
module fetch_ctrl
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc,
   output logic            pc_en,
   output logic [XLEN-1:0] pc_next,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr,
   output logic            if_fault
);

   fetch_state_t    state;
   logic            kill;
   logic [XLEN-1:0] fetch_pc;

   logic [XLEN-1:0] tgt;
   logic            redir;
   logic            tgt_mis;
   logic            gnt_acc;
   logic            outst_after;
   logic            buf_load;
   logic [XLEN-1:0] ld_pc;
   logic [31:0]     ld_instr;

   assign tgt     = trap_valid ? trap_vector : redirect_target;
   assign redir   = !reset && (state != S_BOOT) && (trap_valid || redirect_valid);
   assign tgt_mis = is_misaligned(tgt);

   // Request only when the buffer has room by the time the response lands.
   assign imem_req  = !reset && (state == S_REQ) && (!if_valid || if_ready);
   assign imem_addr = pc;
   assign gnt_acc   = imem_req && imem_gnt;

   // A fetch is still in flight after this cycle: just granted, or waiting
   // (normally or killed inside S_FAULT) with no response yet.
   assign outst_after = gnt_acc ||
                        (((state == S_WAIT) || ((state == S_FAULT) && kill)) && !imem_rvalid);

   assign pc_en = redir || gnt_acc;

   always_comb begin
      pc_next = pc;
      if (reset || (state == S_BOOT)) pc_next = RESET_PC;
      else if (redir)                 pc_next = tgt;
      else if (gnt_acc)               pc_next = pc + XLEN'(4);
   end

   // A redirect loads the buffer only with a misaligned-fetch fault entry;
   // otherwise an unkilled response is captured.
   assign buf_load = redir ? tgt_mis
                           : ((state == S_WAIT) && imem_rvalid && !kill);
   assign ld_pc    = redir ? tgt : fetch_pc;
   assign ld_instr = redir ? NOP_INSTR : imem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_BOOT;
         kill  <= 1'b0;
      end else if (redir) begin
         kill <= outst_after;
         if (tgt_mis)          state <= S_FAULT;
         else if (outst_after) state <= S_WAIT;
         else                  state <= S_REQ;
      end else begin
         case (state)
            S_BOOT:  state <= S_REQ;
            S_REQ:   if (gnt_acc) state <= S_WAIT;
            S_WAIT:  if (imem_rvalid) begin
                        kill  <= 1'b0;
                        state <= S_REQ;
                     end
            S_FAULT: if (imem_rvalid) kill <= 1'b0;
            default: state <= S_BOOT;
         endcase
      end
   end

   // Address of the outstanding fetch, tagged onto its response.
   always_ff @(posedge clk) begin
      if (gnt_acc) fetch_pc <= pc;
   end

   fetch_buf u_buf (
      .clk      (clk),
      .reset    (reset),
      .load     (buf_load),
      .flush    (redir),
      .ready    (if_ready),
      .ld_pc    (ld_pc),
      .ld_instr (ld_instr),
      .ld_fault (redir),
      .valid    (if_valid),
      .pc       (if_pc),
      .instr    (if_instr),
      .fault    (if_fault)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
   import riscv_pkg::*;

   logic            clk;
   logic            reset;
   logic [XLEN-1:0] pc;
   logic            pc_en;
   logic [XLEN-1:0] pc_next;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            trap_valid;
   logic [XLEN-1:0] trap_vector;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;
   logic            if_fault;

   logic            gnt_en;
   logic [1:0]      lat;
   logic            pend;
   logic [1:0]      cnt;
   logic [XLEN-1:0] paddr;

   int n_cmp;
   int n_err;

   fetch_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .pc              (pc),
      .pc_en           (pc_en),
      .pc_next         (pc_next),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .trap_vector     (trap_vector),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_pc           (if_pc),
      .if_instr        (if_instr),
      .if_fault        (if_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External pc register.
   always_ff @(posedge clk) begin
      if (reset)      pc <= RESET_PC;
      else if (pc_en) pc <= pc_next;
   end

   // Instruction memory: grant when enabled, respond lat+1 cycles later with
   // data = address ^ 32'h5A5A0000.
   assign imem_gnt    = imem_req & gnt_en;
   assign imem_rvalid = pend && (cnt == 2'd0);
   assign imem_rdata  = paddr ^ 32'h5A5A_0000;

   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= 1'b0;
         cnt  <= 2'd0;
      end else begin
         if (pend && (cnt != 2'd0)) cnt  <= cnt - 2'd1;
         else if (pend)             pend <= 1'b0;
         if (imem_req && imem_gnt) begin
            pend  <= 1'b1;
            paddr <= imem_addr;
            cnt   <= lat;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      trap_valid      = 1'b0;
      trap_vector     = '0;
      if_ready        = 1'b1;
      gnt_en          = 1'b1;
      lat             = 2'd0;

      tick();
      tick();
      chk1 ("rst_if_valid",  if_valid,  1'b0);
      chk32("rst_if_pc",     if_pc,     32'h0);
      chk32("rst_if_instr",  if_instr,  32'h0);
      chk1 ("rst_if_fault",  if_fault,  1'b0);
      chk1 ("rst_req",       imem_req,  1'b0);
      chk1 ("rst_pc_en",     pc_en,     1'b0);
      chk32("rst_pc_next",   pc_next,   32'h0);
      chk32("rst_addr",      imem_addr, 32'h0);

      // Zero-wait streaming
      reset = 1'b0;
      settle();
      chk1 ("boot_req",   imem_req, 1'b0);
      chk1 ("boot_pc_en", pc_en,    1'b0);
      tick();
      chk1 ("c1_req",     imem_req,  1'b1);
      chk32("c1_addr",    imem_addr, 32'h0);
      chk1 ("c1_pc_en",   pc_en,     1'b1);
      chk32("c1_pc_next", pc_next,   32'h4);
      tick();
      chk1 ("c2_req",     imem_req, 1'b0);
      chk1 ("c2_valid",   if_valid, 1'b0);
      chk32("c2_pc",      pc,       32'h4);
      tick();
      chk1 ("c3_valid",   if_valid,  1'b1);
      chk32("c3_if_pc",   if_pc,     32'h0);
      chk32("c3_instr",   if_instr,  32'h5A5A_0000);
      chk1 ("c3_fault",   if_fault,  1'b0);
      chk1 ("c3_req",     imem_req,  1'b1);
      chk32("c3_addr",    imem_addr, 32'h4);
      tick();
      chk1 ("c4_valid",   if_valid,  1'b0);

      // Decode stall with an entry buffered
      if_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk1 ("hold_valid", if_valid, 1'b1);
         chk32("hold_pc",    if_pc,    32'h4);
         chk32("hold_instr", if_instr, 32'h5A5A_0004);
         chk1 ("hold_req",   imem_req, 1'b0);
         chk32("hold_pcreg", pc,       32'h8);
         tick();
      end
      if_ready = 1'b1;
      settle();
      chk1 ("rel_req",     imem_req,  1'b1);
      chk32("rel_addr",    imem_addr, 32'h8);
      chk32("rel_pc_next", pc_next,   32'hC);
      tick();
      chk1 ("rel_valid0",  if_valid,  1'b0);
      lat = 2'd2;
      tick();
      chk32("rel_if_pc",   if_pc,     32'h8);

      // Branch redirect while waiting on a slow response
      tick();
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_2000;
      settle();
      chk1 ("rd_pc_en",   pc_en,   1'b1);
      chk32("rd_pc_next", pc_next, 32'h0000_2000);
      tick();
      redirect_valid = 1'b0;
      lat = 2'd0;
      settle();
      chk32("rd_pc",      pc,       32'h0000_2000);
      chk1 ("rd_req",     imem_req, 1'b0);
      chk1 ("rd_valid0",  if_valid, 1'b0);
      tick();
      chk1 ("rd_valid1",  if_valid, 1'b0);
      tick();
      chk1 ("rd_discard", if_valid,  1'b0);
      chk1 ("rd_req2",    imem_req,  1'b1);
      chk32("rd_addr",    imem_addr, 32'h0000_2000);
      tick();
      chk32("rd_pc2",     pc,        32'h0000_2004);
      tick();
      chk1 ("rd_valid",   if_valid,  1'b1);
      chk32("rd_if_pc",   if_pc,     32'h0000_2000);
      chk32("rd_instr",   if_instr,  32'h5A5A_2000);

      // Trap and branch together with a grant
      trap_valid      = 1'b1;
      trap_vector     = 32'h0000_0100;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_3000;
      settle();
      chk1 ("tr_req",     imem_req, 1'b1);
      chk1 ("tr_pc_en",   pc_en,    1'b1);
      chk32("tr_pc_next", pc_next,  32'h0000_0100);
      tick();
      trap_valid     = 1'b0;
      redirect_valid = 1'b0;
      settle();
      chk32("tr_pc",      pc,       32'h0000_0100);
      chk1 ("tr_req0",    imem_req, 1'b0);
      tick();
      chk1 ("tr_killed",  if_valid,  1'b0);
      chk1 ("tr_req1",    imem_req,  1'b1);
      chk32("tr_addr",    imem_addr, 32'h0000_0100);
      tick();
      tick();
      chk1 ("tr_valid",   if_valid, 1'b1);
      chk32("tr_if_pc",   if_pc,    32'h0000_0100);
      chk32("tr_instr",   if_instr, 32'h5A5A_0100);

      // Misaligned redirect
      gnt_en          = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_1002;
      settle();
      chk32("mis_pc_next", pc_next, 32'h0000_1002);
      tick();
      redirect_valid = 1'b0;
      gnt_en = 1'b1;
      settle();
      chk1 ("mis_valid", if_valid, 1'b1);
      chk1 ("mis_fault", if_fault, 1'b1);
      chk32("mis_if_pc", if_pc,    32'h0000_1002);
      chk32("mis_instr", if_instr, 32'h0000_0013);
      chk32("mis_pc",    pc,       32'h0000_1002);
      chk1 ("mis_req",   imem_req, 1'b0);
      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1 ("flt_hold_valid", if_valid, 1'b1);
         chk1 ("flt_hold_fault", if_fault, 1'b1);
         chk1 ("flt_hold_req",   imem_req, 1'b0);
      end
      if_ready = 1'b1;
      tick();
      chk1 ("flt_drained", if_valid, 1'b0);
      chk1 ("flt_req0",    imem_req, 1'b0);
      tick();
      chk1 ("flt_req1",    imem_req, 1'b0);
      chk1 ("flt_pc_en",   pc_en,    1'b0);
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_1000;
      settle();
      chk1 ("res_pc_en",   pc_en,   1'b1);
      chk32("res_pc_next", pc_next, 32'h0000_1000);
      tick();
      redirect_valid = 1'b0;
      settle();
      chk1 ("res_req",   imem_req,  1'b1);
      chk32("res_addr",  imem_addr, 32'h0000_1000);
      tick();
      tick();
      chk1 ("res_valid", if_valid, 1'b1);
      chk32("res_if_pc", if_pc,    32'h0000_1000);
      chk1 ("res_fault", if_fault, 1'b0);

      // PC wrap, then reset in S_WAIT with a same-cycle redirect
      gnt_en          = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      settle();
      tick();
      redirect_valid = 1'b0;
      gnt_en = 1'b1;
      settle();
      chk1 ("wr_flushed", if_valid,  1'b0);
      chk1 ("wr_req",     imem_req,  1'b1);
      chk32("wr_addr",    imem_addr, 32'hFFFF_FFFC);
      chk1 ("wr_pc_en",   pc_en,     1'b1);
      chk32("wr_pc_next", pc_next,   32'h0);
      lat = 2'd3;
      tick();
      chk32("wr_pc",      pc,        32'h0);
      lat = 2'd0;
      reset = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_4000;
      settle();
      chk1 ("mr_pc_en",   pc_en,    1'b0);
      chk1 ("mr_req",     imem_req, 1'b0);
      tick();
      reset = 1'b0;
      redirect_valid = 1'b0;
      settle();
      chk1 ("mr_if_valid", if_valid,  1'b0);
      chk32("mr_if_pc",    if_pc,     32'h0);
      chk32("mr_if_instr", if_instr,  32'h0);
      chk1 ("mr_if_fault", if_fault,  1'b0);
      chk1 ("mr_req0",     imem_req,  1'b0);
      chk1 ("mr_pc_en0",   pc_en,     1'b0);
      chk32("mr_pc_next",  pc_next,   32'h0);
      chk32("mr_addr",     imem_addr, 32'h0);
      tick();
      chk1 ("mr_req1",     imem_req,  1'b1);
      chk32("mr_addr1",    imem_addr, 32'h0);
      tick();
      tick();
      chk1 ("mr_valid",    if_valid, 1'b1);
      chk32("mr_if_pc2",   if_pc,    32'h0);
      chk32("mr_instr",    if_instr, 32'h5A5A_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
